// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared definitions for the tristate bus arbiter: FSM state encoding and
// a constant-width helper used to size counters and index ports.
package tristate_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    // Ceiling log2 for elaboration-time width calculation (clog2(1) == 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            result = ((1 << i) < value) ? i + 1 : result;
        end
        return result;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Round-robin picker: finds the first set request bit starting at ptr and
// wrapping modulo NREQ. Purely combinational.
module rr_pick
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    logic [PW-1:0] idx_s;
    logic          valid_s;

    // Scan from the farthest slot back toward ptr so the nearest hit wins.
    always_comb begin
        int j;
        j       = 0;
        idx_s   = {PW{1'b0}};
        valid_s = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j       = (int'(ptr) + k >= NREQ) ? int'(ptr) + k - NREQ : int'(ptr) + k;
            idx_s   = req[PW'(j)] ? PW'(j) : idx_s;
            valid_s = req[PW'(j)] ? 1'b1   : valid_s;
        end
    end

    assign idx   = idx_s;
    assign valid = valid_s;
    assign pick  = valid_s ? (NREQ'(1) << idx_s) : {NREQ{1'b0}};

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencer for a shared tristate bus. One tristate buffer
// enable per requester; owners are separated by all-disabled turnaround
// cycles, and continuous ownership is capped while others are waiting.
module tristate_bus_arbiter
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_HOLD  = 8,
    parameter int TA_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        en,
    output logic [clog2(NREQ)-1:0] owner,
    output logic                   busy
);

    localparam int PW = clog2(NREQ);
    localparam int HW = clog2(MAX_HOLD + 1);
    localparam int TW = clog2(TA_CYCLES + 1);

    state_t          state_r, state_next_s;
    logic [NREQ-1:0] gnt_r, gnt_next_s;
    logic [PW-1:0]   owner_r, owner_next_s;
    logic            busy_r, busy_next_s;
    logic [PW-1:0]   ptr_r, ptr_next_s;
    logic [HW-1:0]   hold_r, hold_next_s;
    logic [TW-1:0]   turn_r, turn_next_s;

    logic [NREQ-1:0] pick_s;
    logic [PW-1:0]   pick_idx_s;
    logic            pick_valid_s;
    logic            hold_max_s;
    logic            others_s;
    logic            release_s;
    logic            turn_last_s;

    // One picker serves both arbitration points (IDLE and last TURN cycle),
    // always scanning from the pointer left behind by the last release.
    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_r),
        .pick  (pick_s),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    assign hold_max_s  = (hold_r == HW'(MAX_HOLD));
    assign others_s    = |(req & ~gnt_r);
    assign release_s   = !req[owner_r] || (hold_max_s && others_s);
    assign turn_last_s = (turn_r == TW'(TA_CYCLES));

    // Next-state and next-output logic for the IDLE/GRANT/TURN sequencer.
    always_comb begin
        state_next_s = state_r;
        gnt_next_s   = gnt_r;
        owner_next_s = owner_r;
        busy_next_s  = busy_r;
        ptr_next_s   = ptr_r;
        hold_next_s  = hold_r;
        turn_next_s  = turn_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_next_s = ST_GRANT;
                    gnt_next_s   = pick_s;
                    owner_next_s = pick_idx_s;
                    busy_next_s  = 1'b1;
                    hold_next_s  = HW'(1);
                end else begin
                    gnt_next_s   = {NREQ{1'b0}};
                    owner_next_s = {PW{1'b0}};
                    busy_next_s  = 1'b0;
                end
            end
            ST_GRANT: begin
                hold_next_s = hold_max_s ? hold_r : hold_r + HW'(1);
                if (release_s) begin
                    state_next_s = ST_TURN;
                    gnt_next_s   = {NREQ{1'b0}};
                    busy_next_s  = 1'b1;
                    ptr_next_s   = (owner_r == PW'(NREQ - 1)) ? {PW{1'b0}} : owner_r + PW'(1);
                    turn_next_s  = TW'(1);
                end else begin
                    state_next_s = ST_GRANT;
                end
            end
            ST_TURN: begin
                if (!turn_last_s) begin
                    turn_next_s = turn_r + TW'(1);
                end else if (pick_valid_s) begin
                    state_next_s = ST_GRANT;
                    gnt_next_s   = pick_s;
                    owner_next_s = pick_idx_s;
                    busy_next_s  = 1'b1;
                    hold_next_s  = HW'(1);
                end else begin
                    state_next_s = ST_IDLE;
                    owner_next_s = {PW{1'b0}};
                    busy_next_s  = 1'b0;
                    turn_next_s  = {TW{1'b0}};
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                gnt_next_s   = {NREQ{1'b0}};
                owner_next_s = {PW{1'b0}};
                busy_next_s  = 1'b0;
                ptr_next_s   = {PW{1'b0}};
                hold_next_s  = {HW{1'b0}};
                turn_next_s  = {TW{1'b0}};
            end
        endcase
    end

    // State and output registers; async reset drops the bus enables at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            gnt_r   <= {NREQ{1'b0}};
            owner_r <= {PW{1'b0}};
            busy_r  <= 1'b0;
            ptr_r   <= {PW{1'b0}};
            hold_r  <= {HW{1'b0}};
            turn_r  <= {TW{1'b0}};
        end else begin
            state_r <= state_next_s;
            gnt_r   <= gnt_next_s;
            owner_r <= owner_next_s;
            busy_r  <= busy_next_s;
            ptr_r   <= ptr_next_s;
            hold_r  <= hold_next_s;
            turn_r  <= turn_next_s;
        end
    end

    assign gnt   = gnt_r;
    assign en    = gnt_r;
    assign owner = owner_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter: one instance with default
// turnaround, one with a three-cycle turnaround.
module tb_tristate_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, gnt, en;
    logic [1:0] owner;
    logic       busy;
    logic [3:0] req3, gnt3, en3;
    logic [1:0] owner3;
    logic       busy3;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    tristate_bus_arbiter #(.NREQ(4), .MAX_HOLD(8), .TA_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt), .en(en), .owner(owner), .busy(busy)
    );

    tristate_bus_arbiter #(.NREQ(4), .MAX_HOLD(8), .TA_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3),
        .gnt(gnt3), .en(en3), .owner(owner3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        check("onehot_en",  {31'd0, ($countones(en)  <= 1)}, 32'd1);
        check("onehot_en3", {31'd0, ($countones(en3) <= 1)}, 32'd1);
        check("en_eq_gnt",  32'(en),  32'(gnt));
        check("en_eq_gnt3", 32'(en3), 32'(gnt3));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        req3  = 4'b1111;

        // Reset holds everything quiet even with all requests set.
        tick();
        tick();
        check("rst_gnt",  32'(gnt),   32'h0);
        check("rst_en",   32'(en),    32'h0);
        check("rst_busy", 32'(busy),  32'h0);
        check("rst_own",  32'(owner), 32'h0);
        check("rst_en3",  32'(en3),   32'h0);
        req   = 4'b0000;
        req3  = 4'b0000;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("idle_gnt",  32'(gnt),  32'h0);
        check("idle_busy", 32'(busy), 32'h0);

        // Single requester: one-cycle latency, then release into turnaround.
        req = 4'b0100;
        tick();
        check("single_gnt",  32'(gnt),   32'h4);
        check("single_own",  32'(owner), 32'h2);
        check("single_busy", 32'(busy),  32'h1);
        for (int i = 0; i < 3; i++) tick();
        check("single_hold", 32'(gnt), 32'h4);
        req = 4'b0000;
        tick();
        check("single_rel_en",   32'(en),   32'h0);
        check("single_rel_busy", 32'(busy), 32'h1);
        tick();
        check("single_idle_busy", 32'(busy), 32'h0);
        check("single_idle_en",   32'(en),   32'h0);

        // Round-robin with all requesting: 8-cycle grants, 1-cycle gaps.
        pulse_reset();
        req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 8; c++) begin
                check("rr_gnt", 32'(gnt),   32'h1 << (g % 4));
                check("rr_own", 32'(owner), 32'(g % 4));
                tick();
            end
            check("rr_gap_en",   32'(en),   32'h0);
            check("rr_gap_busy", 32'(busy), 32'h1);
            tick();
        end

        // Lone requester keeps the bus past MAX_HOLD with no turnaround.
        pulse_reset();
        req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("cap_gnt", 32'(gnt), 32'h1);
        end
        req = 4'b0000;
        tick();
        tick();

        // Three-cycle turnaround between owner 1 and owner 3.
        pulse_reset();
        req3 = 4'b0010;
        tick();
        check("ta3_gnt1", 32'(en3),    32'h2);
        check("ta3_own1", 32'(owner3), 32'h1);
        req3 = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ta3_gap_en",   32'(en3),   32'h0);
            check("ta3_gap_busy", 32'(busy3), 32'h1);
        end
        tick();
        check("ta3_gnt3", 32'(en3),    32'h8);
        check("ta3_own3", 32'(owner3), 32'h3);
        req3 = 4'b0000;
        for (int i = 0; i < 5; i++) tick();

        // Asynchronous reset between edges drops the enable immediately.
        pulse_reset();
        req = 4'b0010;
        tick();
        check("ar_pre_en", 32'(en), 32'h2);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_en",   32'(en),   32'h0);
        check("ar_gnt",  32'(gnt),  32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        req   = 4'b1010;
        tick();
        check("ar_post_gnt", 32'(gnt),   32'h2);
        check("ar_post_own", 32'(owner), 32'h1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
